// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, ALU codes,
// FSM state encoding and trap causes.
package multi_cycle_control_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_FNCT = 3'b111;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExecR  = 4'd3,
    StExecI  = 4'd4,
    StBranch = 4'd5,
    StJump   = 4'd6,
    StMemRd  = 4'd7,
    StMemWr  = 4'd8,
    StWbR    = 4'd9,
    StWbI    = 4'd10,
    StWbMem  = 4'd11,
    StTrap   = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    CauseNone    = 2'b00,
    CauseIllegal = 2'b01,
    CauseTimeout = 2'b10
  } trap_cause_e;

  // States that wait on the memory handshake and therefore ignore Stall.
  function automatic logic is_mem_state(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

  function automatic logic is_stallable(state_e s);
    return (s == StDecode) || (s == StExecR) || (s == StExecI) || (s == StBranch) ||
           (s == StJump) || (s == StWbR) || (s == StWbI) || (s == StWbMem);
  endfunction

endpackage

// File: rtl/multi_cycle_control_timeout.sv
// Memory wait counter: counts cycles without MemAck since the last clear and flags
// the cycle whose miss would bring the count to TIMEOUT.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] Full = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A miss in this cycle while TIMEOUT-1 misses are already recorded is the TIMEOUT-th miss.
  assign expired = count && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != Full)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/memory/
// write-back sequencing with a memory handshake timeout and a sticky trap.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int unsigned OP_W     = 6,
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     Op,
  input  logic                MemAck,
  input  logic                Stall,
  output logic                MemReq,
  output logic                IorD,
  output logic                ReadMem,
  output logic                WriteMem,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic [1:0]          PCSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALU_OP_W-1:0] ALU_Op,
  output logic                WriteReg,
  output logic                MemToReg,
  output logic                DstReg,
  output logic                InstrDone,
  output logic                Trap,
  output logic [1:0]          TrapCause
);

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;
  logic        cnt_clear, cnt_count, cnt_expired;
  logic        is_special, is_beq, is_addi, is_lw, is_sw, is_j;

  assign is_special = (Op == OP_W'(OP_SPECIAL));
  assign is_beq     = (Op == OP_W'(OP_BEQ));
  assign is_addi    = (Op == OP_W'(OP_ADDI));
  assign is_lw      = (Op == OP_W'(OP_LW));
  assign is_sw      = (Op == OP_W'(OP_SW));
  assign is_j       = (Op == OP_W'(OP_J));

  assign cnt_count = is_mem_state(state_q) && !MemAck;
  // Memory states are only ever entered from a different state, so any transition clears.
  assign cnt_clear = (state_d != state_q);

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .count   (cnt_count),
    .expired (cnt_expired)
  );

  assign Trap      = (state_q == StTrap);
  assign TrapCause = cause_q;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    MemReq      = 1'b0;
    IorD        = 1'b0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_Op      = ALU_OP_W'(ALU_NOP);
    WriteReg    = 1'b0;
    MemToReg    = 1'b0;
    DstReg      = 1'b0;
    InstrDone   = 1'b0;

    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        MemReq  = 1'b1;
        ReadMem = 1'b1;
        ALUSrcB = 2'b01;
        ALU_Op  = ALU_OP_W'(ALU_ADD);
        if (MemAck) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StDecode;
        end else if (cnt_expired) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StDecode: begin
        ALUSrcB = 2'b11;
        ALU_Op  = ALU_OP_W'(ALU_ADD);
        if (is_special)                  state_d = StExecR;
        else if (is_addi || is_lw || is_sw) state_d = StExecI;
        else if (is_beq)                 state_d = StBranch;
        else if (is_j)                   state_d = StJump;
        else begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end
      end
      StExecR: begin
        ALUSrcA = 1'b1;
        ALU_Op  = ALU_OP_W'(ALU_FNCT);
        state_d = StWbR;
      end
      StExecI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALU_Op  = ALU_OP_W'(ALU_ADD);
        if (is_addi)    state_d = StWbI;
        else if (is_lw) state_d = StMemRd;
        else if (is_sw) state_d = StMemWr;
        else begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALU_Op      = ALU_OP_W'(ALU_SUB);
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        InstrDone   = 1'b1;
        state_d     = StFetch;
      end
      StJump: begin
        PCWrite   = 1'b1;
        PCSrc     = 2'b10;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StMemRd: begin
        MemReq  = 1'b1;
        ReadMem = 1'b1;
        IorD    = 1'b1;
        if (MemAck) begin
          state_d = StWbMem;
        end else if (cnt_expired) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StMemWr: begin
        MemReq   = 1'b1;
        WriteMem = 1'b1;
        IorD     = 1'b1;
        if (MemAck) begin
          InstrDone = 1'b1;
          state_d   = StFetch;
        end else if (cnt_expired) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StWbR: begin
        WriteReg  = 1'b1;
        DstReg    = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StWbI: begin
        WriteReg  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StWbMem: begin
        WriteReg  = 1'b1;
        MemToReg  = 1'b1;
        InstrDone = 1'b1;
        state_d   = StFetch;
      end
      StTrap: state_d = StTrap;
      default: state_d = StIdle;
    endcase

    // Stall freezes the FSM and suppresses architectural updates; selects stay put.
    if (Stall && is_stallable(state_q)) begin
      state_d     = state_q;
      cause_d     = cause_q;
      WriteReg    = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      InstrDone   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cause_q <= CauseNone;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized and directed bench for multi_cycle_control against an instruction-schedule
// reference model.
module tb_multi_cycle_control;
  import multi_cycle_control_pkg::*;

  localparam int unsigned TIMEOUT = 15;

  typedef enum {SFetch, SDecode, SExecR, SExecI, SBranch, SJump,
                SMemRd, SMemWr, SWbR, SWbI, SWbMem} step_e;

  logic       clk, rst_n, MemAck, Stall;
  logic [5:0] Op;
  logic       MemReq, IorD, ReadMem, WriteMem, IRWrite, PCWrite, PCWriteCond;
  logic [1:0] PCSrc, ALUSrcB, TrapCause;
  logic       ALUSrcA, WriteReg, MemToReg, DstReg, InstrDone, Trap;
  logic [2:0] ALU_Op;
  logic [21:0] dut_vec;

  int n_checks = 0, n_fail = 0;
  int cnt_done, cnt_irw, cnt_wr, cnt_trap;
  logic obs_done;

  // Reference model: a queue of remaining steps for the current instruction.
  step_e sched[$];
  logic  m_idle, m_trap;
  logic [1:0] m_cause;
  int    m_waits;

  multi_cycle_control #(
    .OP_W     (6),
    .ALU_OP_W (3),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Op          (Op),
    .MemAck      (MemAck),
    .Stall       (Stall),
    .MemReq      (MemReq),
    .IorD        (IorD),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSrc       (PCSrc),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALU_Op      (ALU_Op),
    .WriteReg    (WriteReg),
    .MemToReg    (MemToReg),
    .DstReg      (DstReg),
    .InstrDone   (InstrDone),
    .Trap        (Trap),
    .TrapCause   (TrapCause)
  );

  assign dut_vec = {MemReq, IorD, ReadMem, WriteMem, IRWrite, PCWrite, PCWriteCond, PCSrc,
                    ALUSrcA, ALUSrcB, ALU_Op, WriteReg, MemToReg, DstReg, InstrDone, Trap,
                    TrapCause};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [21:0] model_outputs(input logic ack, input logic stl);
    logic mreq, iord, rd, wr, irw, pcw, pcc, srca, wreg, m2r, dst, done;
    logic [1:0] pcsrc, srcb;
    logic [2:0] alu;
    {mreq, iord, rd, wr, irw, pcw, pcc, srca, wreg, m2r, dst, done} = '0;
    pcsrc = 2'b00;
    srcb  = 2'b00;
    alu   = ALU_NOP;
    if (!m_idle && !m_trap) begin
      case (sched[0])
        SFetch:  begin mreq = 1; rd = 1; srcb = 2'b01; alu = ALU_ADD; irw = ack; pcw = ack; end
        SDecode: begin srcb = 2'b11; alu = ALU_ADD; end
        SExecR:  begin srca = 1; alu = ALU_FNCT; end
        SExecI:  begin srca = 1; srcb = 2'b10; alu = ALU_ADD; end
        SBranch: begin srca = 1; alu = ALU_SUB; pcsrc = 2'b01; pcc = !stl; done = !stl; end
        SJump:   begin pcsrc = 2'b10; pcw = !stl; done = !stl; end
        SMemRd:  begin mreq = 1; rd = 1; iord = 1; end
        SMemWr:  begin mreq = 1; wr = 1; iord = 1; done = ack; end
        SWbR:    begin wreg = !stl; dst = 1; done = !stl; end
        SWbI:    begin wreg = !stl; done = !stl; end
        SWbMem:  begin wreg = !stl; m2r = 1; done = !stl; end
        default: ;
      endcase
    end
    return {mreq, iord, rd, wr, irw, pcw, pcc, pcsrc, srca, srcb, alu, wreg, m2r, dst, done,
            m_trap, m_cause};
  endfunction

  task automatic model_reset();
    m_idle  = 1'b1;
    m_trap  = 1'b0;
    m_cause = 2'b00;
    m_waits = 0;
    sched.delete();
  endtask

  task automatic model_step(input logic ack, input logic stl);
    step_e s;
    if (m_idle) begin
      m_idle = 1'b0;
      sched.delete();
      sched.push_back(SFetch);
      m_waits = 0;
      return;
    end
    if (m_trap) return;
    s = sched[0];
    if (s inside {SFetch, SMemRd, SMemWr}) begin
      if (ack) begin
        void'(sched.pop_front());
        m_waits = 0;
        if (s == SFetch) sched.push_back(SDecode);
      end else begin
        m_waits++;
        if (m_waits >= TIMEOUT) begin
          m_trap  = 1'b1;
          m_cause = 2'b10;
        end
      end
    end else if (!stl) begin
      void'(sched.pop_front());
      m_waits = 0;
      if (s == SDecode) begin
        case (Op)
          OP_SPECIAL: begin sched.push_back(SExecR); sched.push_back(SWbR); end
          OP_ADDI:    begin sched.push_back(SExecI); sched.push_back(SWbI); end
          OP_LW:      begin sched.push_back(SExecI); sched.push_back(SMemRd);
                            sched.push_back(SWbMem); end
          OP_SW:      begin sched.push_back(SExecI); sched.push_back(SMemWr); end
          OP_BEQ:     sched.push_back(SBranch);
          OP_J:       sched.push_back(SJump);
          default:    begin m_trap = 1'b1; m_cause = 2'b01; end
        endcase
      end
    end
    if (!m_trap && sched.size() == 0) sched.push_back(SFetch);
  endtask

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic cycle(input logic ack, input logic stl);
    MemAck = ack;
    Stall  = stl;
    #4;
    check_eq("outs", 32'(dut_vec), 32'(model_outputs(ack, stl)));
    obs_done  = InstrDone;
    cnt_done += int'(InstrDone);
    cnt_irw  += int'(IRWrite);
    cnt_wr   += int'(WriteReg);
    cnt_trap += int'(Trap);
    @(posedge clk);
    model_step(ack, stl);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_eq("reset_outs", 32'(dut_vec), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_counts();
    cnt_done = 0;
    cnt_irw  = 0;
    cnt_wr   = 0;
    cnt_trap = 0;
  endtask

  function automatic logic [5:0] pick_op();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 4)  return OP_SPECIAL;
    if (r < 7)  return OP_ADDI;
    if (r < 10) return OP_LW;
    if (r < 13) return OP_SW;
    if (r < 16) return OP_BEQ;
    if (r < 19) return OP_J;
    return ($urandom_range(0, 1) == 0) ? 6'b111111 : 6'b001100;
  endfunction

  initial begin
    logic lw_acks [10];
    int   lw_len;
    int   trap_hold;
    rst_n  = 1'b0;
    MemAck = 1'b0;
    Stall  = 1'b0;
    Op     = OP_SPECIAL;
    model_reset();
    clear_counts();
    @(posedge clk);
    #1;
    do_reset();

    // R-type with MemAck tied high: IDLE, FETCH, DECODE, EXEC_R, WB_R.
    clear_counts();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    check_eq("rtype_done", cnt_done, 1);
    check_eq("rtype_wreg", cnt_wr, 1);

    // LW with 3 fetch wait cycles and 2 memory wait cycles.
    Op = OP_LW;
    clear_counts();
    lw_acks = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    lw_len = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(lw_acks[i], 1'b0);
      if (obs_done && lw_len == 0) lw_len = i + 1;
    end
    check_eq("lw_len", lw_len, 10);
    check_eq("lw_irwrite", cnt_irw, 1);

    // BEQ, then J.
    Op = OP_BEQ;
    clear_counts();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    check_eq("beq_done", cnt_done, 1);
    Op = OP_J;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    check_eq("j_done", cnt_done, 2);

    // Illegal opcode traps after DECODE and stays trapped.
    Op = 6'b111111;
    clear_counts();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check_eq("illegal_trap_cycles", cnt_trap, 20);
    check_eq("illegal_cause", 32'(TrapCause), 32'd1);
    do_reset();
    check_eq("trap_cleared", 32'(Trap), 32'd0);

    // SW whose store is never acknowledged.
    Op = OP_SW;
    cycle(1'b0, 1'b0);
    clear_counts();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < int'(TIMEOUT); i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_eq("timeout_trap", cnt_trap, 1);
    check_eq("timeout_cause", 32'(TrapCause), 32'd2);
    do_reset();

    // SW acknowledged on the last allowed cycle.
    cycle(1'b0, 1'b0);
    clear_counts();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check_eq("late_ack_done", cnt_done, 1);
    check_eq("late_ack_notrap", cnt_trap, 0);

    // ADDI stalled four cycles in WB_I.
    Op = OP_ADDI;
    clear_counts();
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    check_eq("stall_wreg_held", cnt_wr, 0);
    cycle(1'b0, 1'b0);
    check_eq("stall_wreg_once", cnt_wr, 1);

    // Reset asserted while in EXEC_I.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    do_reset();

    // Randomized traffic.
    trap_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (m_trap) begin
        trap_hold++;
        if (trap_hold > 3) begin
          trap_hold = 0;
          do_reset();
          continue;
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      if (!m_idle && !m_trap && sched[0] == SFetch) Op = pick_op();
      cycle(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 25));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle successor to the single-cycle MIPS control decoder: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It drives datapath strobes from the current state and opcode. Memory accesses use a request/acknowledge handshake with a parametrised timeout. It sits between the instruction register / shared instruction-data memory and the existing ALU, register file and PC logic.

## Interface
Parameters:
- OP_W, 6, opcode width
- ALU_OP_W, 3, ALU operation code width (codes from DefVal.v)
- TIMEOUT, 15, max cycles a memory request may wait for MemAck before trapping (≥1)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- Op  input  OP_W  opcode field of the instruction register
- MemAck  input  1  memory completes the current request this cycle
- Stall  input  1  hold current state (ignored in memory-wait states)
- MemReq  output  1  memory request valid
- IorD  output  1  0 = address from PC, 1 = address from ALUOut
- ReadMem, WriteMem  output  1 each  memory read/write qualifier (valid with MemReq)
- IRWrite  output  1  load instruction register
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU Zero
- PCSrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALU_Op  output  ALU_OP_W  ALU operation
- WriteReg, MemToReg, DstReg  output  1 each  register-file write enable, data select (1 = MDR), destination select (1 = rd)
- InstrDone  output  1  one-cycle pulse in final state of each instruction
- Trap  output  1  sticky fault indicator
- TrapCause  output  2  01 illegal opcode, 10 memory timeout, 00 none

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, BRANCH, JUMP, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, TRAP.
- IDLE: all outputs 0; next state FETCH.
- FETCH: MemReq=1, ReadMem=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_Op=ALU_ADD, PCSrc=00. IRWrite=PCWrite=1 only in the cycle MemAck=1; then → DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_Op=ALU_ADD (branch target into ALUOut). Dispatch on Op: SPECIAL→EXEC_R; ADDI, LW, SW→EXEC_I; BEQ→BRANCH; J→JUMP; other→TRAP, cause 01.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALU_Op=ALU_FNCT; → WB_R.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALU_Op=ALU_ADD. Next: ADDI→WB_I, LW→MEM_RD, SW→MEM_WR.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_Op=ALU_SUB, PCWriteCond=1, PCSrc=01, InstrDone=1; → FETCH.
- JUMP: PCWrite=1, PCSrc=10, InstrDone=1; → FETCH.
- MEM_RD: MemReq=1, ReadMem=1, IorD=1; on MemAck → WB_MEM.
- MEM_WR: MemReq=1, WriteMem=1, IorD=1. On MemAck: InstrDone=1, → FETCH.
- WB_R: WriteReg=1, DstReg=1, MemToReg=0. WB_I: WriteReg=1, DstReg=0, MemToReg=0. WB_MEM: WriteReg=1, DstReg=0, MemToReg=1. All three assert InstrDone and → FETCH.
- Timeout: a counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle without MemAck. If the count reaches TIMEOUT and MemAck is still 0 → TRAP, cause 10. MemAck on the TIMEOUT-th cycle wins over the trap.
- TRAP: all strobes 0, Trap=1, TrapCause held; exits only via rst_n.
- Stall=1 in DECODE, EXEC_*, BRANCH, JUMP or WB_* holds state. While stalled, WriteReg, PCWrite, PCWriteCond and InstrDone are forced 0; mux selects and ALU_Op are unchanged.
- Unused selects and ALU_Op default to 0 / ALU_NOP in each state.

## Timing
- Reset (async assert): state=IDLE, counter=0, TrapCause=00; all outputs 0 while rst_n=0. First FETCH occurs one cycle after rst_n deasserts.
- Outputs are combinational from the state register. Exceptions: IRWrite, PCWrite (FETCH) and InstrDone (MEM_WR) also depend on MemAck; stall gating depends on Stall.
- Earliest MemAck is the same cycle MemReq rises.
- Zero-wait cycle counts, FETCH to last state inclusive: BEQ 3, J 3, R-type 4, ADDI 4, SW 4, LW 5. Each memory wait cycle adds 1.
- Reset mid-instruction aborts immediately. No partial write strobe is issued after rst_n falls.

## Structure
- DefVal.v holds the opcode defines (SPECIAL, BEQ, ADDI, LW, SW, new J), the ALU codes (ALU_ADD, ALU_SUB, ALU_FNCT, ALU_NOP), the state encodings, and the TrapCause values.
- One sub-module: mem_timeout_counter, parametrised by TIMEOUT. It has clear, count and expired; its width is clog2(TIMEOUT+1).

## Test plan
- Reset, then R-type (Op=000000) with MemAck tied 1 → states IDLE, FETCH, DECODE, EXEC_R, WB_R. WriteReg=DstReg=1 in cycle 4 after FETCH; InstrDone pulses once.
- LW (100011), MemAck delayed 3 cycles in FETCH and 2 in MEM_RD → IRWrite high exactly 1 cycle. WB_MEM has MemToReg=1. Total 10 cycles.
- BEQ (000100) → PCWriteCond=1, ALU_Op=ALU_SUB, PCSrc=01 in the third cycle. Back to FETCH next.
- Op=111111 → TRAP after DECODE, TrapCause=01, Trap stays high for 20 cycles. Recovers only on rst_n.
- TIMEOUT=15, MemAck never asserted in MEM_WR → TRAP after 15 wait cycles, cause 10. MemAck on cycle 15 → no trap, FETCH follows.
- Stall=1 for 4 cycles in WB_I → WriteReg stays 0 while stalled. Asserts for 1 cycle after release, then FETCH; rst_n pulse mid-EXEC_I → IDLE with all outputs 0.
